bram_sdp_wrinit: RTL and testbench

//  Write-port front end for a simple dual-port BRAM (bram_sdp / bram_sdp_sync). Feeds waddr/din/we.

---
 rtl/bram_sdp_wrinit_pkg.sv | 23 ++
 rtl/bram_sdp_wrinit_if.sv | 26 ++
 rtl/bram_sdp_wrinit.sv | 125 ++++++++++++
 tb/tb_bram_sdp_wrinit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_sdp_wrinit_pkg.sv
// Shared types and helpers for the BRAM write-port initialiser.
// The state type is exported so the parent block and the bench can decode it.
package bram_sdp_wrinit_pkg;

  // Two operating states: sweeping INIT_VAL over the memory, or passing client writes.
  typedef enum logic {
    WRI_CLEAR = 1'b0,
    WRI_RUN   = 1'b1
  } wrinit_state_t;

  // Address width needed to cover n entries (ceil(log2(n)), never below 1).
  function automatic int log2x(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'sd1 <<< (i - 1)) < n) begin
        r = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_sdp_wrinit_if.sv
// Client write-request channel: valid/ready handshake carrying address and data.
interface bram_sdp_wrinit_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;

  // Client side: issues requests, observes ready.
  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  // Block side: accepts requests, drives ready.
  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/bram_sdp_wrinit.sv
// Write-port front end for a simple dual-port BRAM. After reset (or on clr_start)
// it sweeps INIT_VAL over every address, one write per cycle, then forwards client
// requests with a registered one-cycle write path. All outputs are registered.
module bram_sdp_wrinit
  import bram_sdp_wrinit_pkg::*;
#(
  parameter int                DWIDTH      = 32,
  parameter int                DEPTH       = 1024,
  parameter logic [DWIDTH-1:0] INIT_VAL    = {DWIDTH{1'b0}},
  parameter bit                INIT_ON_RST = 1'b1,
  localparam int               AW          = log2x(DEPTH)
) (
  input  logic                wclk,
  input  logic                rst,
  bram_sdp_wrinit_if.slave    req,
  input  logic                clr_start,
  output logic                init_busy,
  output logic                init_done,
  output logic [AW-1:0]       waddr,
  output logic [DWIDTH-1:0]   din,
  output logic                we
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam wrinit_state_t RST_STATE = INIT_ON_RST ? WRI_CLEAR : WRI_RUN;

  wrinit_state_t     state_r, state_s;
  logic [AW-1:0]     cnt_r, cnt_s;
  // Set once the write of the final address has been issued; the following
  // cycle is the tail of the sweep, after which RUN begins.
  logic              last_r, last_s;
  logic              we_r, we_s;
  logic [AW-1:0]     waddr_r, waddr_s;
  logic [DWIDTH-1:0] din_r, din_s;
  logic              ready_r, ready_s;
  logic              busy_r;
  logic              done_r;

  // Next-state and next-output decode for the sweep/pass-through controller.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    last_s  = last_r;
    we_s    = 1'b0;
    waddr_s = waddr_r;
    din_s   = din_r;
    case (state_r)
      WRI_CLEAR: begin
        // clr_start is deliberately not looked at here: a sweep never restarts.
        if (last_r) begin
          state_s = WRI_RUN;
          last_s  = 1'b0;
        end else begin
          we_s    = 1'b1;
          waddr_s = cnt_r;
          din_s   = INIT_VAL;
          if (cnt_r == LAST_ADDR) begin
            cnt_s  = {AW{1'b0}};
            last_s = 1'b1;
          end else begin
            cnt_s  = cnt_r + AW'(1);
          end
        end
      end
      WRI_RUN: begin
        // A request accepted together with clr_start is still written; the
        // sweep that follows overwrites it.
        if (req.req_valid && ready_r) begin
          we_s    = 1'b1;
          waddr_s = req.req_addr;
          din_s   = req.req_data;
        end else begin
          we_s    = 1'b0;
        end
        if (clr_start) begin
          state_s = WRI_CLEAR;
          cnt_s   = {AW{1'b0}};
          last_s  = 1'b0;
        end else begin
          state_s = WRI_RUN;
        end
      end
      default: begin
        // Unreachable encoding: recover by re-clearing the memory.
        state_s = WRI_CLEAR;
        cnt_s   = {AW{1'b0}};
        last_s  = 1'b0;
      end
    endcase
    ready_s = (state_s == WRI_RUN) && !clr_start;
  end

  // State, counter and registered outputs; synchronous reset.
  always_ff @(posedge wclk) begin
    if (rst) begin
      state_r <= RST_STATE;
      cnt_r   <= {AW{1'b0}};
      last_r  <= 1'b0;
      we_r    <= 1'b0;
      waddr_r <= {AW{1'b0}};
      din_r   <= {DWIDTH{1'b0}};
      ready_r <= 1'b0;
      busy_r  <= INIT_ON_RST;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      last_r  <= last_s;
      we_r    <= we_s;
      waddr_r <= waddr_s;
      din_r   <= din_s;
      ready_r <= ready_s;
      busy_r  <= (state_s == WRI_CLEAR);
      done_r  <= (state_s == WRI_RUN);
    end
  end

  assign req.req_ready = ready_r;
  assign we            = we_r;
  assign waddr         = waddr_r;
  assign din           = din_r;
  assign init_busy     = busy_r;
  assign init_done     = done_r;

endmodule

// File: tb/tb_bram_sdp_wrinit.sv
// Bench for bram_sdp_wrinit: DWIDTH=8, DEPTH=12, INIT_VAL=A5. A cycle-level
// behavioural model (cycles-since-clear-start counting) is compared against the
// INIT_ON_RST=1 instance every cycle; directed literal checks pin the model and
// cover the INIT_ON_RST=0 instance.
module tb_bram_sdp_wrinit;
  localparam int         DW    = 8;
  localparam int         DEPTH = 12;
  localparam int         AW    = 4;
  localparam logic [7:0] INIT  = 8'hA5;

  logic wclk = 1'b0;
  logic rst  = 1'b1;
  logic clr0 = 1'b0;
  logic clr1 = 1'b0;
  logic busy0, done0, we0, busy1, done1, we1;
  logic [AW-1:0] waddr0, waddr1;
  logic [DW-1:0] din0, din1;

  int n_checks = 0;
  int n_fail   = 0;

  bram_sdp_wrinit_if #(.AW(AW), .DW(DW)) rif0 ();
  bram_sdp_wrinit_if #(.AW(AW), .DW(DW)) rif1 ();

  bram_sdp_wrinit #(.DWIDTH(DW), .DEPTH(DEPTH), .INIT_VAL(INIT), .INIT_ON_RST(1'b1)) dut0 (
    .wclk(wclk), .rst(rst), .req(rif0), .clr_start(clr0),
    .init_busy(busy0), .init_done(done0), .waddr(waddr0), .din(din0), .we(we0));

  bram_sdp_wrinit #(.DWIDTH(DW), .DEPTH(DEPTH), .INIT_VAL(INIT), .INIT_ON_RST(1'b0)) dut1 (
    .wclk(wclk), .rst(rst), .req(rif1), .clr_start(clr1),
    .init_busy(busy1), .init_done(done1), .waddr(waddr1), .din(din1), .we(we1));

  always #5 wclk = ~wclk;

  // Downstream BRAM model fed by dut0's write port.
  logic [DW-1:0] mem [0:15];
  always @(posedge wclk) begin
    if (we0) mem[waddr0] <= din0;
  end

  // Behavioural model of dut0: m_age counts cycles since a clear began
  // (0 = running). Writes of addresses 0..DEPTH-1 appear in ages 2..DEPTH+1.
  int            m_age   = 0;
  logic          m_valid = 1'b0;
  logic          m_we, m_ready, m_done, m_busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  always @(posedge wclk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_age   <= 1;
      m_we    <= 1'b0;
      m_addr  <= 4'd0;
      m_din   <= 8'd0;
      m_ready <= 1'b0;
      m_done  <= 1'b0;
      m_busy  <= 1'b1;
    end else if (m_age != 0) begin
      if (m_age < DEPTH + 1) begin
        m_age  <= m_age + 1;
        m_we   <= 1'b1;
        m_addr <= 4'(m_age - 1);
        m_din  <= INIT;
      end else begin
        m_age   <= 0;
        m_we    <= 1'b0;
        m_ready <= !clr0;
        m_done  <= 1'b1;
        m_busy  <= 1'b0;
      end
    end else begin
      if (rif0.req_valid && m_ready) begin
        m_we   <= 1'b1;
        m_addr <= rif0.req_addr;
        m_din  <= rif0.req_data;
      end else begin
        m_we   <= 1'b0;
      end
      if (clr0) begin
        m_age   <= 1;
        m_ready <= 1'b0;
        m_done  <= 1'b0;
        m_busy  <= 1'b1;
      end else begin
        m_ready <= 1'b1;
        m_done  <= 1'b1;
        m_busy  <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of dut0 against the model.
  always @(negedge wclk) begin
    if (m_valid) begin
      check("model.we",    32'(we0),    32'(m_we));
      check("model.waddr", 32'(waddr0), 32'(m_addr));
      check("model.din",   32'(din0),   32'(m_din));
      check("model.ready", 32'(rif0.req_ready), 32'(m_ready));
      check("model.done",  32'(done0),  32'(m_done));
      check("model.busy",  32'(busy0),  32'(m_busy));
    end
  end

  // Count sweep writes over a fixed window, checking ascending addresses and INIT data.
  task automatic sweep_window(input string name, input int cycles, output int wc);
    wc = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge wclk);
      clr0 = 1'b0;
      if (we0) begin
        check({name, ".addr"}, 32'(waddr0), 32'(wc));
        check({name, ".din"},  32'(din0),   32'(INIT));
        wc++;
      end
    end
  endtask

  int wc;

  initial begin
    rif0.req_valid = 1'b0; rif0.req_addr = 4'd0; rif0.req_data = 8'd0;
    rif1.req_valid = 1'b0; rif1.req_addr = 4'd0; rif1.req_data = 8'd0;
    repeat (3) @(negedge wclk);
    check("rst.we",    32'(we0), 32'd0);
    check("rst.ready", 32'(rif0.req_ready), 32'd0);
    check("rst.busy",  32'(busy0), 32'd1);
    check("rst.done",  32'(done0), 32'd0);
    rst = 1'b0;

    // 1: power-up sweep of 12 writes, then RUN; readback all A5.
    sweep_window("t1", 20, wc);
    check("t1.count", 32'(wc), 32'd12);
    check("t1.done",  32'(done0), 32'd1);
    check("t1.ready", 32'(rif0.req_ready), 32'd1);
    for (int a = 0; a < DEPTH; a++) check("t1.mem", 32'(mem[a]), 32'h0000_00A5);

    // 2: back-to-back requests, each written one cycle after its handshake.
    rif0.req_valid = 1'b1; rif0.req_addr = 4'd3; rif0.req_data = 8'h11;
    @(negedge wclk);
    check("t2.we0", 32'(we0), 32'd1); check("t2.a0", 32'(waddr0), 32'd3); check("t2.d0", 32'(din0), 32'h11);
    rif0.req_addr = 4'd7; rif0.req_data = 8'h22;
    @(negedge wclk);
    check("t2.we1", 32'(we0), 32'd1); check("t2.a1", 32'(waddr0), 32'd7); check("t2.d1", 32'(din0), 32'h22);
    rif0.req_addr = 4'd3; rif0.req_data = 8'h33;
    @(negedge wclk);
    check("t2.we2", 32'(we0), 32'd1); check("t2.a2", 32'(waddr0), 32'd3); check("t2.d2", 32'(din0), 32'h33);
    rif0.req_valid = 1'b0;
    @(negedge wclk);
    check("t2.idle", 32'(we0), 32'd0);
    check("t2.hold", 32'(waddr0), 32'd3);
    check("t2.mem3", 32'(mem[3]), 32'h33);
    check("t2.mem7", 32'(mem[7]), 32'h22);

    // 3: clr_start together with an accepted request.
    rif0.req_valid = 1'b1; rif0.req_addr = 4'd5; rif0.req_data = 8'h5C; clr0 = 1'b1;
    @(negedge wclk);
    rif0.req_valid = 1'b0; clr0 = 1'b0;
    check("t3.we",    32'(we0), 32'd1);
    check("t3.addr",  32'(waddr0), 32'd5);
    check("t3.din",   32'(din0), 32'h5C);
    check("t3.ready", 32'(rif0.req_ready), 32'd0);
    check("t3.busy",  32'(busy0), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge wclk);
      check("t3.swaddr", 32'(waddr0), 32'(i));
      check("t3.swready", 32'(rif0.req_ready), 32'd0);
    end
    @(negedge wclk);
    check("t3.ready_end", 32'(rif0.req_ready), 32'd1);
    check("t3.done_end",  32'(done0), 32'd1);
    check("t3.mem5",      32'(mem[5]), 32'h0000_00A5);

    // 4: clr_start pulsed at sweep cycle 4 is ignored.
    clr0 = 1'b1;
    wc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge wclk);
      clr0 = 1'b0;
      if (we0) begin
        check("t4.addr", 32'(waddr0), 32'(wc));
        wc++;
        if (wc == 4) clr0 = 1'b1;
      end
    end
    clr0 = 1'b0;
    check("t4.count", 32'(wc), 32'd12);
    check("t4.done",  32'(done0), 32'd1);

    // 5: rst at sweep cycle 6 aborts; a fresh 12-write sweep follows.
    clr0 = 1'b1;
    wc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge wclk);
      clr0 = 1'b0;
      if (we0 && !rst) begin
        wc++;
        if (wc == 6) rst = 1'b1;
      end
    end
    check("t5.abort_at", 32'(wc), 32'd6);
    rst = 1'b1;
    @(negedge wclk);
    check("t5.we",    32'(we0), 32'd0);
    check("t5.waddr", 32'(waddr0), 32'd0);
    rst = 1'b0;
    sweep_window("t5", 20, wc);
    check("t5.count", 32'(wc), 32'd12);

    // 6: INIT_ON_RST=0 instance: no sweep, ready one cycle after rst falls.
    rst = 1'b1;
    repeat (2) @(negedge wclk);
    check("t6.rst_ready", 32'(rif1.req_ready), 32'd0);
    check("t6.rst_we",    32'(we1), 32'd0);
    check("t6.rst_busy",  32'(busy1), 32'd0);
    rst = 1'b0;
    @(negedge wclk);
    check("t6.ready", 32'(rif1.req_ready), 32'd1);
    check("t6.done",  32'(done1), 32'd1);
    check("t6.we0",   32'(we1), 32'd0);
    rif1.req_valid = 1'b1; rif1.req_addr = 4'd0; rif1.req_data = 8'h01;
    @(negedge wclk);
    rif1.req_valid = 1'b0;
    check("t6.we",    32'(we1), 32'd1);
    check("t6.waddr", 32'(waddr1), 32'd0);
    check("t6.din",   32'(din1), 32'h01);
    @(negedge wclk);
    check("t6.idle",  32'(we1), 32'd0);

    repeat (16) @(negedge wclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
